calc_operand_sequencer: RTL and testbench

Control stage directly upstream of the 6-bit ripple adder in the signed calculator. Accepts a signed operand pair plus add/subtract opcode over a valid/ready handshake, registers it, and forms the adder's effective B operand (two's complement negation for subtract). Captures the adder sum one cycle later, computes signed overflow, and presents the result downstream over a second valid/ready handshake. Supports chained accumulation, where the previous result becomes operand A.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_ovf_detect.sv | 44 ++++
 rtl/calc_operand_sequencer.sv | 92 +++++++++
 tb/tb_calc_operand_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the signed calculator operand sequencer.
// Saturation on overflow is selected at build time with CALC_OVF_SAT_EN.
package calc_pkg;

  localparam int CALC_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    HOLD
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic signed [CALC_W-1:0] CALC_MIN = {1'b1, {(CALC_W-1){1'b0}}};
  localparam logic signed [CALC_W-1:0] CALC_MAX = {1'b0, {(CALC_W-1){1'b1}}};

endpackage

// File: rtl/calc_ovf_detect.sv
// Signed overflow detection for the adder sum, with optional saturation of
// the result when CALC_OVF_SAT_EN is defined.
module calc_ovf_detect
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b_eff,
  input  logic [W-1:0] sum,
  input  logic [W-1:0] b_orig,
  input  logic         sub,
  output logic         ovf,
  output logic [W-1:0] result
);

  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
`ifdef CALC_OVF_SAT_EN
  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
`endif

  // Negating the most negative value wraps onto itself, so the generic sign
  // rule would be wrong; A - MIN overflows exactly when A is non-negative.
  always_comb begin
    if (sub == OP_SUB && b_orig == MIN_V) begin
      ovf = ~a[W-1];
    end else begin
      ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
    end
  end

  always_comb begin
`ifdef CALC_OVF_SAT_EN
    if (ovf) begin
      result = a[W-1] ? MIN_V : MAX_V;
    end else begin
      result = sum;
    end
`else
    result = sum;
`endif
  end

endmodule

// File: rtl/calc_operand_sequencer.sv
// Operand sequencer feeding an external ripple adder: accept, issue, capture,
// hold result. Build option CALC_OVF_SAT_EN saturates overflowed results.
module calc_operand_sequencer
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_sub,
  input  logic         op_chain,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_rst,
  input  logic [W-1:0] add_s,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_ovf
);

  state_t       state;
  logic [W-1:0] b_q;
  logic         sub_q;
  logic [W-1:0] last_res;
  logic         ovf;
  logic [W-1:0] ovf_result;

  assign op_ready = (state == IDLE) && !rst;
  assign add_rst  = rst || (state == IDLE);

  calc_ovf_detect #(.W(W)) u_ovf (
    .a      (add_a),
    .b_eff  (add_b),
    .sum    (add_s),
    .b_orig (b_q),
    .sub    (sub_q),
    .ovf    (ovf),
    .result (ovf_result)
  );

  // add_a/add_b stay stable through CAPTURE so add_s is still valid when sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      add_a     <= '0;
      add_b     <= '0;
      b_q       <= '0;
      sub_q     <= OP_ADD;
      last_res  <= '0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            add_a <= op_chain ? last_res : op_a;
            add_b <= (op_sub == OP_SUB) ? (~op_b + W'(1)) : op_b;
            b_q   <= op_b;
            sub_q <= op_sub;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          res_data  <= ovf_result;
          res_ovf   <= ovf;
          last_res  <= ovf_result;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Self-checking bench for calc_operand_sequencer: directed cases plus random
// traffic, checked every cycle against an arithmetic reference model.
module tb_calc_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [5:0] op_a;
  logic [5:0] op_b;
  logic       op_sub;
  logic       op_chain;
  logic [5:0] add_a;
  logic [5:0] add_b;
  logic       add_rst;
  logic [5:0] add_s;
  logic       res_valid;
  logic       res_ready;
  logic [5:0] res_data;
  logic       res_ovf;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: cycles since acceptance (0 = idle, 3 = holding).
  int         m_phase = 0;
  int         m_last = 0;
  int         m_accepts = 0;
  bit         m_armed = 0;
  bit         m_fresh = 0;
  logic [5:0] m_add_a = '0;
  logic [5:0] m_add_b = '0;
  logic [5:0] m_pend_data = '0;
  logic       m_pend_ovf = 1'b0;
  logic [5:0] m_res_data = '0;
  logic       m_res_ovf = 1'b0;

  always #5 clk = ~clk;

  // Behavioural model of the external ripple adder.
  assign add_s = add_rst ? 6'd0 : 6'(add_a + add_b);

  calc_operand_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .op_chain  (op_chain),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_rst   (add_rst),
    .add_s     (add_s),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf)
  );

  function automatic void modelOp(input int a, input int b, input bit sub,
                                  output logic [5:0] data, output logic ovf);
    int t;
    t   = sub ? a - b : a + b;
    ovf = (t > 31) || (t < -32);
`ifdef CALC_OVF_SAT_EN
    if (ovf) data = (t > 31) ? 6'd31 : 6'b100000;
    else     data = 6'(t);
`else
    data = 6'(t);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int a;
    int b;
    if (rst) begin
      m_armed    = 1;
      m_fresh    = 1;
      m_phase    = 0;
      m_last     = 0;
      m_add_a    = '0;
      m_add_b    = '0;
      m_res_data = '0;
      m_res_ovf  = 1'b0;
    end else begin
      case (m_phase)
        0: if (op_valid) begin
          a = op_chain ? m_last : int'($signed(op_a));
          b = int'($signed(op_b));
          m_add_a = 6'(a);
          m_add_b = 6'(op_sub ? -b : b);
          modelOp(a, b, op_sub, m_pend_data, m_pend_ovf);
          m_accepts++;
          m_phase = 1;
        end
        1: m_phase = 2;
        2: begin
          m_res_data = m_pend_data;
          m_res_ovf  = m_pend_ovf;
          m_last     = int'($signed(m_pend_data));
          m_fresh    = 0;
          m_phase    = 3;
        end
        default: if (res_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      checkOutput("op_ready", op_ready, (m_phase == 0) && !rst);
      checkOutput("res_valid", res_valid, m_phase == 3);
      checkOutput("add_rst", add_rst, rst || (m_phase == 0));
      if (m_phase == 3 || m_fresh) begin
        checkOutput("res_data", res_data, m_res_data);
        checkOutput("res_ovf", res_ovf, m_res_ovf);
      end
      if (m_phase == 1 || m_phase == 2 || m_fresh) begin
        checkOutput("add_a", add_a, m_add_a);
        checkOutput("add_b", add_b, m_add_b);
      end
    end
  end

  // Presents one request and keeps it valid until the model records acceptance.
  task automatic applyStimulus(input logic [5:0] a, input logic [5:0] b,
                               input logic sub, input logic chain, input bit rnd);
    int start;
    bit done;
    start    = m_accepts;
    done     = 0;
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    op_chain = chain;
    op_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      #1;
      if (m_accepts != start) done = 1;
      else if (rnd) res_ready = 1'($urandom_range(1));
    end
    op_valid = 1'b0;
    checkOutput("accept_timeout", done, 1);
  endtask

  task automatic runOp(input logic [5:0] a, input logic [5:0] b, input logic sub,
                       input logic chain, input logic [5:0] exp_data, input logic exp_ovf,
                       input logic [5:0] exp_addb, input int hold);
    int cnt;
    res_ready = (hold == 0);
    applyStimulus(a, b, sub, chain, 0);
    @(negedge clk);
    checkOutput("lit_add_b", add_b, exp_addb);
    cnt = 0;
    while (m_phase != 3 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("lit_latency", cnt, 2);
    checkOutput("lit_res_data", res_data, exp_data);
    checkOutput("lit_res_ovf", res_ovf, exp_ovf);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("lit_hold_data", res_data, exp_data);
      checkOutput("lit_hold_ready", op_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    op_chain  = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("lit_rst_op_ready", op_ready, 0);
    checkOutput("lit_rst_res_valid", res_valid, 0);
    checkOutput("lit_rst_add_rst", add_rst, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("lit_idle_op_ready", op_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] directed operations");
    runOp(6'd5, 6'd7, 1'b0, 1'b0, 6'd12, 1'b0, 6'd7, 0);
    runOp(6'd3, 6'd10, 1'b1, 1'b0, 6'b111001, 1'b0, 6'b110110, 0);
`ifdef CALC_OVF_SAT_EN
    runOp(6'd20, 6'd15, 1'b0, 1'b0, 6'd31, 1'b1, 6'd15, 0);
    runOp(6'd0, 6'b100000, 1'b1, 1'b0, 6'd31, 1'b1, 6'b100000, 0);
`else
    runOp(6'd20, 6'd15, 1'b0, 1'b0, 6'b100011, 1'b1, 6'd15, 0);
    runOp(6'd0, 6'b100000, 1'b1, 1'b0, 6'b100000, 1'b1, 6'b100000, 0);
`endif
    runOp(6'b111111, 6'b100000, 1'b1, 1'b0, 6'd31, 1'b0, 6'b100000, 0);
    runOp(6'd10, 6'd4, 1'b0, 1'b0, 6'd14, 1'b0, 6'd4, 5);
    runOp(6'd0, 6'd6, 1'b1, 1'b1, 6'd8, 1'b0, 6'b111010, 0);

    $display("[TB] reset during capture");
    applyStimulus(6'd7, 6'd8, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("lit_rstcap_res_valid", res_valid, 0);
    checkOutput("lit_rstcap_op_ready", op_ready, 1);
    @(posedge clk);
    #1;
    runOp(6'd0, 6'd9, 1'b0, 1'b1, 6'd9, 1'b0, 6'd9, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 150; n++) begin
      logic [5:0] ra;
      logic [5:0] rb;
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(3, 1)) begin
          res_ready = 1'($urandom_range(1));
          @(posedge clk);
          #1;
        end
      end
      ra = 6'($urandom);
      rb = ($urandom_range(7) == 0) ? 6'b100000 : 6'($urandom);
      applyStimulus(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)), 1);
    end
    res_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
